// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the parametrised Booth multiplier.
// Contents: FSM state enum, recode-operation enum, radix selection and a
// counter-width helper.
// Build option: BOOTH_RADIX4_EN selects radix-4 recoding (default radix-2).
package booth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_Q,
        ITER,
        CORR,
        OUT_HI,
        OUT_LO
    } state_e;

    typedef enum logic [2:0] {
        NOP,
        ADD_M,
        SUB_M,
        ADD_2M,
        SUB_2M
    } booth_op_e;

`ifdef BOOTH_RADIX4_EN
    localparam bit RADIX4_EN = 1'b1;
`else
    localparam bit RADIX4_EN = 1'b0;
`endif

    // Bits needed to count iterations 0..N-1, N = WIDTH or WIDTH/2.
    function automatic int cnt_width(input int width, input bit radix4);
        int n;
        int w;
        n = radix4 ? width / 2 : width;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/booth_recoder.sv
// booth_recoder: combinational Booth digit recoder.
// Ports:
//   bits_i  in  3  {Q[1:0], Q_1}
//   op_o    out    recode operation (booth_op_e)
// Build option: BOOTH_RADIX4_EN selects radix-4 recoding; otherwise only
// Q[0] and Q_1 are examined.
module booth_recoder
    import booth_pkg::*;
(
    input  logic [2:0] bits_i,
    output booth_op_e  op_o
);

`ifdef BOOTH_RADIX4_EN
    always_comb begin
        op_o = NOP;
        case (bits_i)
            3'b001, 3'b010: op_o = ADD_M;
            3'b011:         op_o = ADD_2M;
            3'b100:         op_o = SUB_2M;
            3'b101, 3'b110: op_o = SUB_M;
            default:        op_o = NOP;
        endcase
    end
`else
    logic unused_q1;
    assign unused_q1 = bits_i[2];

    always_comb begin
        op_o = NOP;
        case (bits_i[1:0])
            2'b01:   op_o = ADD_M;
            2'b10:   op_o = SUB_M;
            default: op_o = NOP;
        endcase
    end
`endif

endmodule

// File: rtl/booth_mul_param.sv
// booth_mul_param: sequential signed/unsigned Booth multiplier with a serial
// operand/product bus.
// Ports:
//   clk     in  1      rising-edge clock
//   rst_b   in  1      asynchronous active-low reset
//   bgn     in  1      start request, sampled only in IDLE
//   uns     in  1      1 = unsigned operands, sampled with bgn
//   inbus   in  WIDTH  M in the bgn cycle, Q in the following cycle
//   stop    out 1      marks the low product word
//   outbus  out WIDTH  high product word, then low product word, else 0
// Build option: BOOTH_RADIX4_EN selects radix-4 recoding (WIDTH/2 iterations,
// +-2M path); undefined gives radix-2 (WIDTH iterations, no 2M path).
//
// state  | meaning
// IDLE   | waiting for bgn; M and uns captured on bgn
// LOAD_Q | capture Q, clear A/Q_1/counter, latch Q MSB
// ITER   | one Booth step per cycle: add/sub then arithmetic shift
// CORR   | unsigned fix-up: add M to A when original Q MSB was set
// OUT_HI | outbus = A[WIDTH-1:0]
// OUT_LO | outbus = Q, stop = 1
module booth_mul_param
    import booth_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             bgn,
    input  logic             uns,
    input  logic [WIDTH-1:0] inbus,
    output logic             stop,
    output logic [WIDTH-1:0] outbus
);

    localparam int EXT   = WIDTH + 2;
    localparam int N     = RADIX4_EN ? WIDTH / 2 : WIDTH;
    localparam int CNT_W = cnt_width(WIDTH, RADIX4_EN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic [EXT-1:0]   m_q, m_d;
    logic [EXT-1:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q1_q, q1_d;
    logic             uns_q, uns_d;
    logic             qmsb_q, qmsb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    booth_op_e        op;
    logic [EXT-1:0]   addend;
    logic             sub;
    logic [EXT-1:0]   sum;

    booth_recoder u_recoder (
        .bits_i ({q_q[1:0], q1_q}),
        .op_o   (op)
    );

    // Single shared adder; subtraction is inverted operand plus carry-in.
    always_comb begin
        addend = '0;
        sub    = 1'b0;
        if (state_q == CORR) begin
            addend = (uns_q && qmsb_q) ? m_q : '0;
        end else begin
            case (op)
                ADD_M: addend = m_q;
                SUB_M: begin
                    addend = m_q;
                    sub    = 1'b1;
                end
`ifdef BOOTH_RADIX4_EN
                ADD_2M: addend = {m_q[EXT-2:0], 1'b0};
                SUB_2M: begin
                    addend = {m_q[EXT-2:0], 1'b0};
                    sub    = 1'b1;
                end
`endif
                default: addend = '0;
            endcase
        end
    end

    assign sum = a_q + (addend ^ {EXT{sub}}) + {{(EXT-1){1'b0}}, sub};

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        q1_d    = q1_q;
        uns_d   = uns_q;
        qmsb_d  = qmsb_q;
        cnt_d   = cnt_q;
        stop    = 1'b0;
        outbus  = '0;

        case (state_q)
            IDLE: begin
                if (bgn) begin
                    m_d     = uns ? {2'b00, inbus} : {{2{inbus[WIDTH-1]}}, inbus};
                    uns_d   = uns;
                    state_d = LOAD_Q;
                end
            end
            LOAD_Q: begin
                q_d     = inbus;
                qmsb_d  = inbus[WIDTH-1];
                a_d     = '0;
                q1_d    = 1'b0;
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
`ifdef BOOTH_RADIX4_EN
                {a_d, q_d, q1_d} = {sum[EXT-1], sum[EXT-1], sum, q_q[WIDTH-1:1]};
`else
                {a_d, q_d, q1_d} = {sum[EXT-1], sum, q_q};
`endif
                if (cnt_q == CNT_LAST) begin
                    state_d = CORR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CORR: begin
                a_d     = sum;
                state_d = OUT_HI;
            end
            OUT_HI: begin
                outbus  = a_q[WIDTH-1:0];
                state_d = OUT_LO;
            end
            OUT_LO: begin
                outbus  = q_q;
                stop    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            uns_q   <= 1'b0;
            qmsb_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            uns_q   <= uns_d;
            qmsb_q  <= qmsb_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/booth_mul_param.md
# booth_mul_param

Parametrised sequential Booth multiplier: the next-generation multiply unit of the ALU. It generalises the fixed 64-bit radix-2 signed Booth multiplier to any even operand width and adds signed/unsigned operation. It optionally uses radix-4 recoding, which halves the iteration count. It keeps the established serial-bus protocol: operands arrive on `inbus` on consecutive cycles after `bgn`, and the 2·WIDTH product leaves on `outbus` as high word then low word, with `stop` marking the final word.

## Interface
- `WIDTH`, default 64: operand width; must be even and at least 4. The product is 2·WIDTH bits.
- `clk`  in  1  rising-edge clock.
- `rst_b`  in  1  asynchronous active-low reset.
- `bgn`  in  1  start request; sampled only in IDLE.
- `uns`  in  1  1 = unsigned operands, 0 = two's-complement; sampled together with `bgn`.
- `inbus`  in  WIDTH  operand bus: multiplicand M in the `bgn` cycle, multiplier Q in the following cycle.
- `stop`  out  1  high for exactly one cycle, concurrent with the low product word.
- `outbus`  out  WIDTH  product words; 0 whenever not in OUT_HI or OUT_LO.

## Operation
- **Registers.**
  - M is extended to EXT = WIDTH+2 bits: sign-extended if `uns`=0, zero-extended if `uns`=1.
  - A is EXT bits; Q is WIDTH bits; Q_1 is 1 bit; `uns_r` holds the sampled `uns`; plus an iteration counter.
- **States:** IDLE, LOAD_Q, ITER, CORR, OUT_HI, OUT_LO.
- **IDLE.**
  - If `bgn`=1: capture M from `inbus`, capture `uns_r`, and go to LOAD_Q.
  - If `bgn`=0: stay in IDLE.
- **LOAD_Q.** Q←`inbus`, A←0, Q_1←0, counter←0, then go to ITER.
- **ITER, radix-2.**
  - Recode {Q[0],Q_1}: 01 → A+=M; 10 → A−=M; 00 and 11 → no operation.
  - Then arithmetic-right-shift the combined {A,Q,Q_1} by 1.
- **ITER, radix-4.**
  - Recode {Q[1:0],Q_1}: 000/111 → 0; 001/010 → +M; 011 → +2M; 100 → −2M; 101/110 → −M.
  - Then arithmetic-right-shift {A,Q,Q_1} by 2.
- **ITER exit.** Leave ITER after N iterations; N = WIDTH (radix-2) or WIDTH/2 (radix-4).
- **CORR.** Always exactly one cycle.
  - If `uns_r`=1 and the original Q MSB was 1, then A+=M. This corrects for Booth treating Q as signed.
  - Otherwise no operation.
  - The original Q MSB is latched in LOAD_Q.
- **OUT_HI.** `outbus` = A[WIDTH-1:0].
- **OUT_LO.** `outbus` = Q, `stop`=1, then go to IDLE.
- **Arithmetic.** All additions are EXT-bit modulo. Each subtraction is performed as addition of the inverted operand with carry-in 1. The product fits 2·WIDTH bits in both modes.
- **`bgn` while busy.** `bgn` is ignored in every state except IDLE, including the OUT_LO cycle.
- **`inbus` and `uns` while busy.** Both are ignored outside the IDLE `bgn` cycle and the LOAD_Q cycle.
- **Reset.** Asynchronous reset from any state returns to IDLE and clears all registers, `stop`, and `outbus`. No partial result is emitted.

## Timing
- Let cycle 0 be the rising edge at which `bgn`=1 is sampled in IDLE.
- Sequence:
  - Cycle 1: LOAD_Q.
  - Cycles 2..N+1: ITER.
  - Cycle N+2: CORR.
  - Cycle N+3: OUT_HI.
  - Cycle N+4: OUT_LO, with `stop`=1.
  - Cycle N+5: back in IDLE, where a new `bgn` is accepted.
- Latency is fixed and data-independent.
  - WIDTH=64, radix-2: `stop` at cycle 68.
  - WIDTH=64, radix-4: `stop` at cycle 36.
- Reset values: `stop`=0, `outbus`=0, state=IDLE.

## Configuration
- `BOOTH_RADIX4_EN` defined:
  - radix-4 recoding with ±M and ±2M selection.
  - 2-bit shift per iteration; N = WIDTH/2.
  - The counter is sized for WIDTH/2.
- `BOOTH_RADIX4_EN` undefined:
  - radix-2 recoding; 1-bit shift per iteration; N = WIDTH.
  - No 2M path is synthesised.
- All other behaviour and the interface are identical in both builds.

## Structure
- Package `booth_pkg` contains:
  - the state enum (IDLE, LOAD_Q, ITER, CORR, OUT_HI, OUT_LO);
  - the recode-operation enum (NOP, ADD_M, SUB_M, ADD_2M, SUB_2M);
  - a function returning the counter width for a given WIDTH and radix.
- Sub-module `booth_recoder`: combinational. It takes {Q[1:0],Q_1} and returns a recode operation. In radix-2 builds only Q[0] and Q_1 are used.
- The top level contains the FSM, registers, counter, and a single EXT-bit adder/subtractor.

## Test plan
- WIDTH=64, `uns`=0, M=7, Q=−3 → OUT_HI = 0xFFFF_FFFF_FFFF_FFFF, OUT_LO = 0xFFFF_FFFF_FFFF_FFEB.
- WIDTH=64, `uns`=1, M=Q=0xFFFF_FFFF_FFFF_FFFF → OUT_HI = 0xFFFF_FFFF_FFFF_FFFE, OUT_LO = 0x0000_0000_0000_0001. With `uns`=0 and the same operands → OUT_HI = 0, OUT_LO = 1.
- WIDTH=64, `uns`=0, M=Q=0x8000_0000_0000_0000 → OUT_HI = 0x4000_0000_0000_0000, OUT_LO = 0. `stop` is seen at cycle 68 (radix-2) or 36 (radix-4).
- WIDTH=8, `uns`=0, M=0x80 (−128), Q=0x7F (127) → OUT_HI = 0xC0, OUT_LO = 0x80.
- Assert `bgn` with new operands during ITER → ignored; the original product is output unchanged and only one `stop` pulse occurs.
- Pulse `rst_b` low during ITER → `outbus`=0 and `stop`=0 immediately. A fresh operation afterwards (M=5, Q=6) → OUT_LO = 30, OUT_HI = 0.
